// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types and defaults for the FIFO stream reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int STATS_W        = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_reader_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_reader_skid
//  Description : Two-entry order-preserving skid buffer; the head register
//                drives the downstream data directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid
);

    logic [1:0]       r_occ;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else if (clear) begin
            r_occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= push_data;
                    else               r_tail <= push_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy unchanged, queue shifts.
                    if (r_occ == 2'd1) begin
                        r_head <= push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign occ        = r_occ;
    assign head_data  = r_head;
    assign head_valid = (r_occ != 2'd0);

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : FIFO read-side controller issuing rd_en on credit and
//                presenting words on a valid/ready stream. Optional counters
//                enabled by defining FIFO_READER_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  empty,
    input  logic                  underflow,
    input  logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  underflow_err,
    output logic [STATS_W-1:0]    words_out,
    output logic [STATS_W-1:0]    stall_cycles
);

    if (FIFO_DEPTH < 1 || FIFO_DEPTH > (1 << STATS_W) - 1) begin : g_depth_check
        $error("FIFO_DEPTH out of range for the statistics counters");
    end

    reader_state_e r_state;
    reader_state_e w_state_nxt;
    logic          r_pend;
    logic          r_underflow_err;
    logic [1:0]    w_occ;
    logic          w_pop;
    logic          w_push;
    logic [2:0]    w_credit;

    assign w_pop    = m_valid & m_ready;
    // Words held or in flight after this cycle's pop; doubles as next occupancy in DRAIN.
    assign w_credit = {1'b0, w_occ} + {2'b00, r_pend} - {2'b00, w_pop};
    assign rd_en    = (r_state == RUN) & ~empty & ~flush & (w_credit < 3'd2);
    assign w_push   = r_pend & ~flush;

    fifo_reader_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_data  (data_out),
        .pop        (w_pop & ~flush),
        .clear      (flush),
        .occ        (w_occ),
        .head_data  (m_data),
        .head_valid (m_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_pend          <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pend          <= rd_en;
            r_underflow_err <= r_underflow_err | underflow;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = en ? RUN : IDLE;
        end else begin
            case (r_state)
                IDLE:    if (en) w_state_nxt = RUN;
                RUN:     if (!en) w_state_nxt = ((w_occ != 2'd0) || r_pend) ? DRAIN : IDLE;
                DRAIN: begin
                    if (en)                      w_state_nxt = RUN;
                    else if (w_credit == 3'd0)   w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign busy          = (r_state != IDLE) | (w_occ != 2'd0) | r_pend;
    assign underflow_err = r_underflow_err;

`ifdef FIFO_READER_STATS_EN
    logic [STATS_W-1:0] r_words_out;
    logic [STATS_W-1:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_words_out    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_pop && !flush && (r_words_out != {STATS_W{1'b1}}))
                r_words_out <= r_words_out + 1'b1;
            if (m_valid && !m_ready && (r_stall_cycles != {STATS_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign words_out    = r_words_out;
    assign stall_cycles = r_stall_cycles;
`else
    assign words_out    = '0;
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_stream_reader
//  Description : Scoreboard bench for fifo_stream_reader with a FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int W = 16;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          flush;
    logic          empty;
    logic          underflow = 1'b0;
    logic [W-1:0]  data_out = '0;
    logic          rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          busy;
    logic          underflow_err;
    logic [15:0]   words_out;
    logic [15:0]   stall_cycles;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .flush         (flush),
        .empty         (empty),
        .underflow     (underflow),
        .data_out      (data_out),
        .rd_en         (rd_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .busy          (busy),
        .underflow_err (underflow_err),
        .words_out     (words_out),
        .stall_cycles  (stall_cycles)
    );

    // FIFO model with one-cycle read latency
    logic [W-1:0] mem [0:D-1];
    logic [2:0]   wptr = '0;
    logic [2:0]   rptr = '0;
    int           cnt  = 0;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         m_clr;

    assign empty = (cnt == 0);

    always @(posedge clk) begin
        if (m_clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= 0;
        end else begin
            underflow <= rd_en && (cnt == 0);
            if (rd_en && cnt != 0) begin
                data_out <= mem[rptr];
                rptr     <= rptr + 3'd1;
            end
            if (wr_en) begin
                mem[wptr] <= wr_data;
                wptr      <= wptr + 3'd1;
            end
            cnt <= cnt + (wr_en ? 1 : 0) - ((rd_en && cnt != 0) ? 1 : 0);
        end
    end

    int           checks = 0;
    int           errors = 0;
    int           rd_cnt = 0;
    int           hs_cnt = 0;
    int           cyc = 0;
    int           last_hs_cyc = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every downstream handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) rd_cnt++;
            if (m_valid && m_ready && !flush) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", m_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("stream_data", {16'h0, m_data}, {16'h0, mon_exp});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + W'(i);
            exp_q.push_back(base + W'(i));
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk(name, {31'h0, n < 60}, 32'h1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk(name, {31'h0, n < 60}, 32'h1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!m_valid && n < 30) begin
            tick();
            n++;
        end
        chk(name, {31'h0, n < 30}, 32'h1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"},         {31'h0, rd_en},         32'h0);
        chk({tag, "_m_valid"},       {31'h0, m_valid},       32'h0);
        chk({tag, "_m_data"},        {16'h0, m_data},        32'h0);
        chk({tag, "_busy"},          {31'h0, busy},          32'h0);
        chk({tag, "_underflow_err"}, {31'h0, underflow_err}, 32'h0);
        chk({tag, "_words_out"},     {16'h0, words_out},     32'h0);
        chk({tag, "_stall_cycles"},  {16'h0, stall_cycles},  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_rd, t_v, n, rd0, h0, rem;
        int w0, s0;
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
        wr_en = 1'b0; wr_data = '0; m_clr = 1'b1;
        tick();
        tick();
        m_clr = 1'b0;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Burst of 8 with m_ready high
        preload(16'h0001, 8);
        m_ready = 1'b1;
        w0 = int'(words_out);
        s0 = int'(stall_cycles);
        en = 1'b1;
        t_rd = -1; t_v = -1; n = 0;
        while (t_v < 0 && n < 20) begin
            @(negedge clk);
            if (rd_en && t_rd < 0) t_rd = cyc;
            if (m_valid) t_v = cyc;
            n++;
        end
        chk("first_word_latency", t_v - t_rd, 2);
        wait_drained("burst_drain");
        chk("burst_back_to_back", last_hs_cyc - t_v, 7);
`ifdef FIFO_READER_STATS_EN
        chk("burst_words_out", int'(words_out) - w0, 8);
        chk("burst_stall_cycles", int'(stall_cycles) - s0, 0);
`endif
        en = 1'b0;
        wait_idle("burst_idle");

        // Backpressure: hold m_ready low for 5 valid cycles
        m_ready = 1'b0;
        preload(16'h0001, 4);
        rd0 = rd_cnt;
        w0 = int'(words_out);
        s0 = int'(stall_cycles);
        en = 1'b1;
        wait_valid("bp_valid");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_data", {16'h0, m_data}, 32'h0001);
            tick();
        end
        chk("bp_rd_pulses", rd_cnt - rd0, 2);
        m_ready = 1'b1;
        wait_drained("bp_drain");
`ifdef FIFO_READER_STATS_EN
        chk("bp_stall_cycles", int'(stall_cycles) - s0, 5);
        chk("bp_words_out", int'(words_out) - w0, 4);
`endif
        en = 1'b0;
        wait_idle("bp_idle");

        // Single word into an empty FIFO
        m_ready = 1'b1;
        en = 1'b1;
        tick();
        tick();
        rd0 = rd_cnt;
        h0 = hs_cnt;
        preload(16'h00AB, 1);
        wait_drained("single_drain");
        tick();
        tick();
        tick();
        chk("single_rd_pulses", rd_cnt - rd0, 1);
        chk("single_words", hs_cnt - h0, 1);
        chk("single_underflow_err", {31'h0, underflow_err}, 32'h0);
        en = 1'b0;
        wait_idle("single_idle");

        // Drop en around the 2nd handshake
        m_ready = 1'b1;
        preload(16'h0201, 6);
        h0 = hs_cnt;
        en = 1'b1;
        n = 0;
        while (hs_cnt < h0 + 1 && n < 20) begin
            tick();
            n++;
        end
        en = 1'b0;
        wait_idle("en_drop_idle");
        rem = cnt;
        chk("en_drop_remaining", {31'h0, (rem >= 2 && rem <= 3)}, 32'h1);
        chk("en_drop_delivered", hs_cnt - h0, 6 - rem);
        chk("en_drop_scoreboard", exp_q.size(), rem);
        for (int i = 0; i < rem; i++) void'(exp_q.pop_back());
        m_clr = 1'b1;
        tick();
        m_clr = 1'b0;

        // Flush with two words held
        m_ready = 1'b0;
        preload(16'h0A01, 4);
        en = 1'b1;
        wait_valid("flush_valid");
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_rd_en", {31'h0, rd_en}, 32'h0);
        tick();
        flush = 1'b0;
        chk("flush_clears_valid", {31'h0, m_valid}, 32'h0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        m_ready = 1'b1;
        wait_drained("flush_resume");
        en = 1'b0;
        wait_idle("flush_idle");

        // Asynchronous reset mid-burst
        m_ready = 1'b1;
        preload(16'h0301, 8);
        h0 = hs_cnt;
        en = 1'b1;
        n = 0;
        while (hs_cnt < h0 + 3 && n < 20) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("post_reset_fifo_nonempty", {31'h0, empty}, 32'h0);
        chk_reset_outputs("post_reset");
        exp_q.delete();
        m_clr = 1'b1;
        tick();
        m_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
